ptp_rx_stamp: RTL

//  Receive-side counterpart of the TX timestamp inserter. Sits on the GMII RX path, between the PHY and the MAC/host.
//  - Passes every byte through with a fixed 1-cycle delay.
//  - Detects fake PTP frames (DMAC 00_01_02_03_04_05) and writes the local receive time into the receive-timestamp field that matches the frame's type.
//  - Extracts type and t0..t3 and reports them to the sync logic as a single-cycle record.

---
 rtl/ptp_rx_stamp.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ptp_rx_stamp.sv
// GMII RX pass-through that recognises fake PTP frames, writes the local receive time into the
// type-specific receive-timestamp field and reports type plus t0..t3 as a single-cycle record.
module ptp_rx_stamp #(
    parameter logic [47:0] PTP_DMAC = 48'h000102030405,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gmii_dv_i,
    input  logic [7:0]       gmii_data_i,
    input  logic             gmii_er_i,
    input  logic [15:0]      local_time,
    output logic             gmii_dv_o,
    output logic [7:0]       gmii_data_o,
    output logic             gmii_er_o,
    output logic             ptp_valid_o,
    output logic [1:0]       ptp_type_o,
    output logic [15:0]      ptp_t0_o,
    output logic [15:0]      ptp_t1_o,
    output logic [15:0]      ptp_t2_o,
    output logic [15:0]      ptp_t3_o,
    output logic [CNT_W-1:0] cnt_pkt_o,
    output logic [CNT_W-1:0] cnt_ptp_o
);

    localparam logic [7:0] SFD = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SFD,
        DMAC,
        TYPE,
        FIELDS,
        REPORT,
        WAIT_TAIL
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  bcnt, bcnt_nxt;
    logic [15:0] rx_time;
    logic [1:0]  ptp_type;
    logic [15:0] t0, t1, t2, t3;
    logic        rx_armed;
    logic [7:0]  dmac_byte;
    logic [7:0]  rx_byte;
    logic        start, type_we, field_we, report, stamp_en;

    always_comb begin
        case (bcnt)
            4'd0:    dmac_byte = PTP_DMAC[47:40];
            4'd1:    dmac_byte = PTP_DMAC[39:32];
            4'd2:    dmac_byte = PTP_DMAC[31:24];
            4'd3:    dmac_byte = PTP_DMAC[23:16];
            4'd4:    dmac_byte = PTP_DMAC[15:8];
            default: dmac_byte = PTP_DMAC[7:0];
        endcase
    end

    // In FIELDS bcnt 3,4 are offsets 10,11 and bcnt 7,8 are offsets 14,15; odd counts carry the high byte.
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        start     = 1'b0;
        type_we   = 1'b0;
        field_we  = 1'b0;
        report    = 1'b0;
        stamp_en  = 1'b0;
        case (state)
            IDLE: begin
                if (gmii_dv_i && rx_armed) begin
                    start     = 1'b1;
                    state_nxt = WAIT_SFD;
                end
            end
            WAIT_SFD: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end else if (gmii_data_i == SFD) begin
                    state_nxt = DMAC;
                    bcnt_nxt  = 4'd0;
                end
            end
            DMAC: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end else if (gmii_er_i || gmii_data_i != dmac_byte) begin
                    state_nxt = WAIT_TAIL;
                end else if (bcnt == 4'd5) begin
                    state_nxt = TYPE;
                end else begin
                    bcnt_nxt = bcnt + 4'd1;
                end
            end
            TYPE: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end else if (gmii_er_i) begin
                    state_nxt = WAIT_TAIL;
                end else begin
                    type_we   = 1'b1;
                    state_nxt = FIELDS;
                    bcnt_nxt  = 4'd0;
                end
            end
            FIELDS: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end else if (gmii_er_i) begin
                    state_nxt = WAIT_TAIL;
                end else begin
                    field_we = 1'b1;
                    stamp_en = (ptp_type == 2'd1 && (bcnt == 4'd3 || bcnt == 4'd4)) ||
                               (ptp_type == 2'd2 && (bcnt == 4'd7 || bcnt == 4'd8));
                    if (bcnt == 4'd8) begin
                        state_nxt = REPORT;
                    end else begin
                        bcnt_nxt = bcnt + 4'd1;
                    end
                end
            end
            REPORT: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end else begin
                    report    = 1'b1;
                    state_nxt = WAIT_TAIL;
                end
            end
            WAIT_TAIL: begin
                if (!gmii_dv_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_byte = stamp_en ? (bcnt[0] ? rx_time[15:8] : rx_time[7:0]) : gmii_data_i;

    // rx_armed stays low after reset until dv is seen low, so a frame cut by reset is ignored entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcnt        <= 4'd0;
            rx_time     <= 16'd0;
            ptp_type    <= 2'd0;
            t0          <= 16'd0;
            t1          <= 16'd0;
            t2          <= 16'd0;
            t3          <= 16'd0;
            rx_armed    <= 1'b0;
            gmii_dv_o   <= 1'b0;
            gmii_data_o <= 8'd0;
            gmii_er_o   <= 1'b0;
            ptp_valid_o <= 1'b0;
            ptp_type_o  <= 2'd0;
            ptp_t0_o    <= 16'd0;
            ptp_t1_o    <= 16'd0;
            ptp_t2_o    <= 16'd0;
            ptp_t3_o    <= 16'd0;
            cnt_pkt_o   <= '0;
            cnt_ptp_o   <= '0;
        end else begin
            state       <= state_nxt;
            bcnt        <= bcnt_nxt;
            rx_armed    <= rx_armed | ~gmii_dv_i;
            gmii_dv_o   <= gmii_dv_i & rx_armed;
            gmii_er_o   <= gmii_er_i & rx_armed;
            gmii_data_o <= rx_armed ? rx_byte : 8'd0;
            ptp_valid_o <= report;
            if (start) begin
                rx_time   <= local_time;
                cnt_pkt_o <= cnt_pkt_o + CNT_W'(1);
            end
            if (type_we) begin
                ptp_type <= gmii_data_i[1:0];
            end
            if (field_we) begin
                case (bcnt)
                    4'd1, 4'd2: t0 <= {t0[7:0], rx_byte};
                    4'd3, 4'd4: t1 <= {t1[7:0], rx_byte};
                    4'd5, 4'd6: t2 <= {t2[7:0], rx_byte};
                    4'd7, 4'd8: t3 <= {t3[7:0], rx_byte};
                    default: ;
                endcase
            end
            if (report) begin
                ptp_type_o <= ptp_type;
                ptp_t0_o   <= t0;
                ptp_t1_o   <= t1;
                ptp_t2_o   <= t2;
                ptp_t3_o   <= t3;
                cnt_ptp_o  <= cnt_ptp_o + CNT_W'(1);
            end
        end
    end

endmodule
